// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter owning a shared 4:1 mux with bounded hold

// Plain 4:1 single-bit mux selected by {s1,s0}.
module mux4_1 (
   input  logic d0,
   input  logic d1,
   input  logic d2,
   input  logic d3,
   input  logic s1,
   input  logic s0,
   output logic y
);

   // Select one of four data bits.
   always_comb begin
      case ({s1, s0})
         2'b00:   y = d0;
         2'b01:   y = d1;
         2'b10:   y = d2;
         default: y = d3;
      endcase
   end

endmodule

module mux4_rr_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       i0,
   input  logic       i1,
   input  logic       i2,
   input  logic       i3,
   output logic [3:0] grant,
   output logic       s1,
   output logic       s0,
   output logic       valid,
   output logic       out
);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     state_q;
   logic [1:0] ptr_q;
   logic [7:0] hold_cnt_q;
   logic [3:0] grant_q;
   logic [1:0] sel_q;
   logic       valid_q;

   logic [1:0] owner;
   logic [3:0] others;
   logic       at_sat;
   logic       rel;
   logic [1:0] scan_start;
   logic [3:0] scan_mask;
   logic       found;
   logic [1:0] found_idx;
   logic       mux_y;

   // Arbitration scan: from ptr in IDLE, from owner+1 over the other requesters in BUSY.
   always_comb begin
      owner      = sel_q;
      others     = req & ~grant_q;
      at_sat     = (hold_cnt_q == HOLD_LAST);
      rel        = !req[owner] || (at_sat && (|others));
      scan_start = (state_q == ST_BUSY) ? owner + 2'd1 : ptr_q;
      scan_mask  = (state_q == ST_BUSY) ? others : req;
      found      = 1'b0;
      found_idx  = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!found && scan_mask[scan_start + 2'(i)]) begin
            found     = 1'b1;
            found_idx = scan_start + 2'(i);
         end
      end
   end

   // Arbiter FSM with registered grant, select and valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= 2'd0;
         hold_cnt_q <= 8'd0;
         grant_q    <= 4'd0;
         sel_q      <= 2'd0;
         valid_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               hold_cnt_q <= 8'd0;
               if (found) begin
                  state_q <= ST_BUSY;
                  grant_q <= 4'b0001 << found_idx;
                  sel_q   <= found_idx;
                  valid_q <= 1'b1;
               end else begin
                  grant_q <= 4'd0;
                  sel_q   <= 2'd0;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               if (rel) begin
                  ptr_q      <= owner + 2'd1;
                  hold_cnt_q <= 8'd0;
                  if (found) begin
                     grant_q <= 4'b0001 << found_idx;
                     sel_q   <= found_idx;
                     valid_q <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                     grant_q <= 4'd0;
                     sel_q   <= 2'd0;
                     valid_q <= 1'b0;
                  end
               end else if (!at_sat) begin
                  hold_cnt_q <= hold_cnt_q + 8'd1;
               end
            end
         endcase
      end
   end

   mux4_1 u_mux (
      .d0 (i0),
      .d1 (i1),
      .d2 (i2),
      .d3 (i3),
      .s1 (sel_q[1]),
      .s0 (sel_q[0]),
      .y  (mux_y)
   );

   assign grant = grant_q;
   assign s1    = sel_q[1];
   assign s0    = sel_q[0];
   assign valid = valid_q;
   assign out   = valid_q & mux_y;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] req_b;
   logic       i0, i1, i2, i3;
   logic [3:0] grant, grant_b;
   logic       s1, s0, valid, out;
   logic       s1_b, s0_b, valid_b, out_b;

   int checks;
   int failures;

   mux4_rr_arbiter #(.MAX_HOLD(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .i0(i0), .i1(i1), .i2(i2), .i3(i3),
      .grant(grant), .s1(s1), .s0(s0), .valid(valid), .out(out)
   );

   mux4_rr_arbiter #(.MAX_HOLD(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b),
      .i0(i0), .i1(i1), .i2(i2), .i3(i3),
      .grant(grant_b), .s1(s1_b), .s0(s0_b), .valid(valid_b), .out(out_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic [3:0] g, input logic [1:0] sel,
                              input logic v, input logic o);
      check({tag, "_grant"}, 32'(grant), 32'(g));
      check({tag, "_sel"},   32'({s1, s0}), 32'(sel));
      check({tag, "_valid"}, 32'(valid), 32'(v));
      check({tag, "_out"},   32'(out), 32'(o));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 4'd0;
      req_b = 4'd0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] exp_seq [5];
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      req      = 4'd0;
      req_b    = 4'd0;
      {i3, i2, i1, i0} = 4'b1111;
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      // Reset state
      #1;
      check_state("reset", 4'd0, 2'd0, 1'b0, 1'b0);

      // Single request on line 2, one-cycle latency, out follows i2
      do_reset();
      req = 4'b0100;
      check_state("idle_before_edge", 4'd0, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      check_state("grant2", 4'b0100, 2'b10, 1'b1, 1'b1);
      i2 = 1'b0;
      #1;
      check("grant2_out_follows", 32'(out), 32'd0);
      i2 = 1'b1;

      // All requesting: each owner holds exactly 8 cycles, rotation 0,1,2,3,0
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("rot_o%0d_c%0d", k, c), 32'(grant), 32'(exp_seq[k]));
         end
      end

      // Owner 1 alone drops after 3 cycles -> idle; then 0011 grants 0 (ptr=2 wraps)
      do_reset();
      req = 4'b0010;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("own1_c%0d", c), 32'(grant), 32'h2);
      end
      req = 4'b0000;
      @(negedge clk);
      check_state("own1_drop", 4'd0, 2'd0, 1'b0, 1'b0);
      req = 4'b0011;
      @(negedge clk);
      check_state("after_wrap", 4'b0001, 2'b00, 1'b1, 1'b1);

      // Lone requester 3 for 20 cycles, no rotation
      do_reset();
      req = 4'b1000;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check($sformatf("lone3_c%0d", c), 32'(grant), 32'h8);
      end
      check_state("lone3_final", 4'b1000, 2'b11, 1'b1, 1'b1);

      // Asynchronous reset between edges while busy
      #2;
      rst_n = 1'b0;
      #1;
      check_state("async_rst", 4'd0, 2'd0, 1'b0, 1'b0);
      #1;
      rst_n = 1'b1;

      // MAX_HOLD=1 alternates every cycle between 0 and 2
      do_reset();
      req_b = 4'b0101;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("mh1_c%0d", c), 32'(grant_b), (c % 2 == 0) ? 32'h1 : 32'h4);
         check($sformatf("mh1_sel_c%0d", c), 32'({s1_b, s0_b}), (c % 2 == 0) ? 32'd0 : 32'd2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
